axi_lite_read_arbiter: RTL
==========================

Name: axi_lite_read_arbiter

Overview:
- Shares the single AXI4-lite read master between two requesters: instruction fetch (IFU) and load/store unit (LSU).
- Sits between the requesters and the read master's request/finish side. It arbitrates round-robin, sequences exactly one outstanding read at a time, and routes returned data to the granted requester.
- An optional watchdog aborts a read that never completes.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
TIMEOUT, 256, max cycles in WAIT before abort; 0 disables the watchdog
CNT_W, 9, watchdog counter width; must hold TIMEOUT

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
ifu_req  in  1  IFU read request; held until ifu_done
ifu_addr  in  ADDR_W  IFU address; stable while ifu_req high
ifu_done  out  1  one-cycle completion pulse to IFU
ifu_err  out  1  valid with ifu_done; 1 = aborted by timeout
ifu_data  out  DATA_W  read data; valid with ifu_done, held afterwards
lsu_req, lsu_addr, lsu_done, lsu_err, lsu_data  same as the IFU group, for the LSU
m_req  out  1  one-cycle request pulse to the read master
m_addr  out  ADDR_W  registered address to the read master; held from ISSUE through WAIT
m_finish  in  1  read master completion, sampled each cycle
m_data  in  DATA_W  read master data; valid when m_finish is high
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, RST=1): state=IDLE, rr_ptr=LSU, all outputs 0, data registers 0, counter 0. Reset mid-transaction discards the read. The read master shares RST, so no stale finish can follow.
- IDLE:
  - If any req is high, pick the winner and latch its ID into owner and its address into m_addr, then go to ISSUE.
  - Winner with one requester: that requester.
  - Winner with both: the one selected by rr_ptr (rr_ptr names the preferred requester).
- ISSUE: m_req=1 for exactly this cycle, then go to WAIT with the counter cleared.
- WAIT:
  - Counter increments each cycle.
  - m_finish=1: capture m_data into owner's data register, set owner's done=1 and err=0 for the next cycle, toggle rr_ptr away from owner, go to DONE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: set owner's done=1, err=1, data=0, toggle rr_ptr, go to DRAIN.
  - m_finish in the same cycle as the timeout condition counts as a normal finish (finish wins).
- DONE: the done pulse is visible this cycle. All reqs are ignored this cycle so the requester can drop req. Next state is IDLE.
- DRAIN: the done/err pulse is visible on the first DRAIN cycle. Stay in DRAIN until m_finish=1; discard that data and return to IDLE. New requests wait.
- Latency: req high in IDLE at cycle 0 gives m_req at cycle 1. m_finish at cycle k gives done at cycle k+1. Earliest next grant is at cycle k+2.
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- done/err are single-cycle pulses, and only the owner's done can pulse. *_data holds its value until overwritten by that requester's next completion.
- A req that drops before being granted is not serviced. A req that drops after grant does not abort the read.
- m_finish outside WAIT/DRAIN is ignored.

Decomposition:
- Shared package `axi_lite_pkg`:
  - state enum {IDLE, ISSUE, WAIT, DONE, DRAIN}
  - requester ID constants REQ_IFU=0, REQ_LSU=1
  - default widths
- One natural sub-module, `rr_arb2`: a two-way round-robin arbiter, combinational grant plus registered pointer, advanced by an update strobe.

Test Plan:
1. LSU only, lsu_addr=0x8000_0010; m_finish after 3 WAIT cycles with m_data=0xDEAD_BEEF → m_req one pulse with m_addr=0x8000_0010; lsu_done at cycle 6 with lsu_data=0xDEAD_BEEF, lsu_err=0; ifu_done stays 0.
2. Both requesting from reset, held: IFU 0x100, LSU 0x200 → grant order LSU, IFU, LSU, IFU; m_addr sequence 0x200, 0x100, 0x200, 0x100.
3. TIMEOUT=4, IFU request, no m_finish → ifu_done=1 with ifu_err=1 and ifu_data=0 four cycles after entering WAIT. A later LSU request gets no m_req until m_finish arrives (drained), then is serviced normally.
4. m_finish on the exact cycle the counter hits TIMEOUT-1 → normal completion with err=0 and real data, no DRAIN.
5. Assert RST asynchronously mid-WAIT → outputs 0 immediately, state IDLE. After release, a fresh IFU request completes normally and rr_ptr=LSU.
6. Spurious m_finish in IDLE → no done pulse, no state change.

Source files
------------

// File: rtl/axi_lite_read_arbiter_pkg.sv
// ============================================================================
// Module   : axi_lite_pkg
// Brief    : Shared types and constants for the AXI4-lite read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_lite_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   localparam logic REQ_IFU = 1'b0;
   localparam logic REQ_LSU = 1'b1;

   localparam int DEF_ADDR_W  = 64;
   localparam int DEF_DATA_W  = 64;
   localparam int DEF_TIMEOUT = 256;
   localparam int DEF_CNT_W   = 9;

endpackage

`default_nettype wire

// File: rtl/axi_lite_read_arbiter_if.sv
// ============================================================================
// Module   : axi_lite_read_arbiter_if
// Brief    : Requester and read-master signals of the read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_lite_read_arbiter_if
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              ifu_req;
   logic [ADDR_W-1:0] ifu_addr;
   logic              ifu_done;
   logic              ifu_err;
   logic [DATA_W-1:0] ifu_data;

   logic              lsu_req;
   logic [ADDR_W-1:0] lsu_addr;
   logic              lsu_done;
   logic              lsu_err;
   logic [DATA_W-1:0] lsu_data;

   logic              m_req;
   logic [ADDR_W-1:0] m_addr;
   logic              m_finish;
   logic [DATA_W-1:0] m_data;
   logic              busy;

   // The arbiter masters the shared read port.
   modport master (
      input  ifu_req, ifu_addr, lsu_req, lsu_addr, m_finish, m_data,
      output ifu_done, ifu_err, ifu_data, lsu_done, lsu_err, lsu_data,
      output m_req, m_addr, busy
   );

   modport slave (
      output ifu_req, ifu_addr, lsu_req, lsu_addr, m_finish, m_data,
      input  ifu_done, ifu_err, ifu_data, lsu_done, lsu_err, lsu_data,
      input  m_req, m_addr, busy
   );

endinterface

`default_nettype wire

// File: rtl/axi_lite_read_arbiter_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter; combinational grant, registered
//            preference pointer moved away from the owner on each update.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
   import axi_lite_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic [1:0] req,
   input  wire logic       update,
   input  wire logic       owner,
   output logic            any,
   output logic            grant
);

   logic r_ptr;

   always_comb begin
      any   = |req;
      grant = (req == 2'b11) ? r_ptr : req[REQ_LSU];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= REQ_LSU;
      end else if (update) begin
         r_ptr <= ~owner;
      end
   end

endmodule

`default_nettype wire

// File: rtl/axi_lite_read_arbiter.sv
// ============================================================================
// Module   : axi_lite_read_arbiter
// Brief    : Shares one AXI4-lite read master between IFU and LSU with
//            round-robin grant, one outstanding read and a timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_read_arbiter
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
)(
   input  wire logic              clk,
   input  wire logic              rst,
   axi_lite_read_arbiter_if.master bus
);

   localparam bit               c_TMO_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] c_TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   state_t            r_state;
   logic              r_owner;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_m_req;
   logic [ADDR_W-1:0] r_m_addr;
   logic              r_busy;
   logic              r_ifu_done;
   logic              r_ifu_err;
   logic [DATA_W-1:0] r_ifu_data;
   logic              r_lsu_done;
   logic              r_lsu_err;
   logic [DATA_W-1:0] r_lsu_data;

   logic              w_any;
   logic              w_grant;
   logic              w_tmo;
   logic              w_end;
   logic              w_abort;
   logic [DATA_W-1:0] w_cpl_data;

   // A finish in the timeout cycle wins over the abort.
   assign w_tmo      = c_TMO_EN && (r_cnt == c_TMO_LAST);
   assign w_end      = (r_state == WAIT) && (bus.m_finish || w_tmo);
   assign w_abort    = ~bus.m_finish;
   assign w_cpl_data = bus.m_finish ? bus.m_data : '0;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    ({bus.lsu_req, bus.ifu_req}),
      .update (w_end),
      .owner  (r_owner),
      .any    (w_any),
      .grant  (w_grant)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_owner    <= REQ_IFU;
         r_cnt      <= '0;
         r_m_req    <= 1'b0;
         r_m_addr   <= '0;
         r_busy     <= 1'b0;
         r_ifu_done <= 1'b0;
         r_ifu_err  <= 1'b0;
         r_ifu_data <= '0;
         r_lsu_done <= 1'b0;
         r_lsu_err  <= 1'b0;
         r_lsu_data <= '0;
      end else begin
         r_m_req    <= 1'b0;
         r_ifu_done <= 1'b0;
         r_ifu_err  <= 1'b0;
         r_lsu_done <= 1'b0;
         r_lsu_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_owner  <= w_grant;
                  r_m_addr <= (w_grant == REQ_LSU) ? bus.lsu_addr : bus.ifu_addr;
                  r_m_req  <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= ISSUE;
               end
            end
            ISSUE: begin
               r_cnt   <= '0;
               r_state <= WAIT;
            end
            WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_end) begin
                  if (r_owner == REQ_LSU) begin
                     r_lsu_done <= 1'b1;
                     r_lsu_err  <= w_abort;
                     r_lsu_data <= w_cpl_data;
                  end else begin
                     r_ifu_done <= 1'b1;
                     r_ifu_err  <= w_abort;
                     r_ifu_data <= w_cpl_data;
                  end
                  r_state <= bus.m_finish ? DONE : DRAIN;
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            DRAIN: begin
               // The late finish of an aborted read is swallowed here.
               if (bus.m_finish) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.m_req    = r_m_req;
   assign bus.m_addr   = r_m_addr;
   assign bus.busy     = r_busy;
   assign bus.ifu_done = r_ifu_done;
   assign bus.ifu_err  = r_ifu_err;
   assign bus.ifu_data = r_ifu_data;
   assign bus.lsu_done = r_lsu_done;
   assign bus.lsu_err  = r_lsu_err;
   assign bus.lsu_data = r_lsu_data;

endmodule

`default_nettype wire
